bxu_io_port: RTL

- Peripheral-side responder for the BXU core's byte I/O handshake.
- Supplies input bytes to the core over the io_input_ready/io_input_done four-phase handshake, from a small input FIFO fed by an external valid/ready stream.
- Accepts output bytes from the core over the io_output_ready/io_output_done four-phase handshake and presents them on an external valid/ready stream.

---
 rtl/bxu_io_port.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bxu_io_port.sv
// Peripheral-side responder for the BXU core byte I/O handshakes: a small input FIFO feeding the
// core over a four-phase input handshake, and a one-entry holding register draining core output.
module bxu_io_port #(
   parameter int unsigned DATA_BITWIDTH = 8,
   parameter int unsigned IN_FIFO_AW    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     io_input_ready,
   input  logic                     io_input_done,
   output logic [DATA_BITWIDTH-1:0] io_input_data,
   input  logic                     io_output_ready,
   input  logic [DATA_BITWIDTH-1:0] io_output_data,
   output logic                     io_output_done,
   input  logic [DATA_BITWIDTH-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_BITWIDTH-1:0] m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [IN_FIFO_AW:0]      in_count
);

   localparam int unsigned Depth = 2 ** IN_FIFO_AW;
   localparam logic [IN_FIFO_AW:0] DepthCnt = (IN_FIFO_AW + 1)'(Depth);

   typedef enum logic [1:0] {IIdle, IOffer, IRelease} in_state_e;
   typedef enum logic [0:0] {OIdle, OAck} out_state_e;

   logic [DATA_BITWIDTH-1:0] mem_q [Depth];
   logic [IN_FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [IN_FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [IN_FIFO_AW:0]      count_q, count_d;
   logic                     push, pop;

   in_state_e                in_state_q, in_state_d;
   logic [DATA_BITWIDTH-1:0] in_data_q, in_data_d;

   out_state_e               out_state_q, out_state_d;
   logic [DATA_BITWIDTH-1:0] m_data_q, m_data_d;
   logic                     m_valid_q, m_valid_d;
   logic                     capture;

   // ---------------- input FIFO ----------------
   assign s_ready = (count_q != DepthCnt);
   assign push    = s_valid && s_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   // Storage needs no reset: pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_data;
   end

   // ---------------- input handshake FSM ----------------
   always_comb begin
      in_state_d = in_state_q;
      in_data_d  = in_data_q;
      pop        = 1'b0;
      unique case (in_state_q)
         IIdle: begin
            if ((count_q != '0) && !io_input_done) begin
               in_data_d  = mem_q[rd_ptr_q];
               in_state_d = IOffer;
            end
         end
         IOffer: begin
            if (io_input_done) begin
               pop        = 1'b1;
               in_state_d = IRelease;
            end
         end
         IRelease: begin
            if (!io_input_done) in_state_d = IIdle;
         end
         default: in_state_d = IIdle;
      endcase
   end

   // ---------------- output handshake FSM ----------------
   // Holding register is free when empty or being drained this cycle.
   assign capture = (out_state_q == OIdle) && io_output_ready && (!m_valid_q || m_ready);

   always_comb begin
      out_state_d = out_state_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      if (m_valid_q && m_ready) m_valid_d = 1'b0;
      unique case (out_state_q)
         OIdle: begin
            if (capture) begin
               m_data_d    = io_output_data;
               m_valid_d   = 1'b1;
               out_state_d = OAck;
            end
         end
         OAck: begin
            if (!io_output_ready) out_state_d = OIdle;
         end
         default: out_state_d = OIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_state_q  <= IIdle;
         in_data_q   <= '0;
         out_state_q <= OIdle;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_state_q  <= in_state_d;
         in_data_q   <= in_data_d;
         out_state_q <= out_state_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
      end
   end

   assign io_input_ready  = (in_state_q == IOffer);
   assign io_input_data   = in_data_q;
   assign io_output_done  = (out_state_q == OAck);
   assign m_data          = m_data_q;
   assign m_valid         = m_valid_q;
   assign in_count        = count_q;

endmodule
